// File: rtl/os_sched_pkg.sv
// Shared definitions for the TX ordered-set scheduler and the RX ordered-set decoder:
// ordered-set command encodings, the scheduler state encoding, the EIOS count per
// generation and the 8b/10b / 128b/130b symbol constants.
package os_sched_pkg;

  typedef enum logic [2:0] {
    OS_NONE = 3'd0,
    OS_TS1  = 3'd1,
    OS_TS2  = 3'd2,
    OS_SKP  = 3'd3,
    OS_EIOS = 3'd4
  } os_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TS   = 2'd1,
    ST_SKP  = 2'd2,
    ST_EIOS = 2'd3
  } state_e;

  localparam logic [1:0] EIOS_CNT_LOW  = 2'd1;  // gen 1-2
  localparam logic [1:0] EIOS_CNT_HIGH = 2'd2;  // gen 3 and above

  // Symbol constants shared with the RX decoder
  localparam logic [7:0] COM      = 8'hBC;
  localparam logic [7:0] gen3TS1  = 8'h1E;
  localparam logic [7:0] gen3TS2  = 8'h2D;
  localparam logic [7:0] gen3SKIP = 8'hAA;

  // Number of EIOS to send before electrical idle for a given generation
  function automatic logic [1:0] eios_count(input logic [2:0] gen);
    return (gen >= 3'd3) ? EIOS_CNT_HIGH : EIOS_CNT_LOW;
  endfunction

endpackage

// File: rtl/os_tx_scheduler_if.sv
// Ordered-set command bus between the scheduler (master) and the TX ordered-set
// generator (slave).
//   osValid  : command valid
//   osType   : command type, stable while osValid is high until transfer
//   genReady : generator accepts the command this cycle
interface os_tx_scheduler_if;
  import os_sched_pkg::*;

  logic     osValid;
  os_type_e osType;
  logic     genReady;

  modport master (output osValid, output osType, input genReady);
  modport slave  (input osValid, input osType, output genReady);

endinterface

// File: rtl/os_skp_timer.sv
// SKP schedule timer: counts while the link is up and raises skpPending every
// SKP_INTERVAL cycles; flags an overrun when an interval expires with a SKP still owed.
//   clk, reset (async, active-low), linkUp : timer enable, skpTaken : SKP transferred
//   skpPending : SKP owed, skpOverrun : one-cycle overrun pulse
module os_skp_timer #(
  parameter int unsigned SKP_INTERVAL = 1180
) (
  input  logic clk,
  input  logic reset,
  input  logic linkUp,
  input  logic skpTaken,
  output logic skpPending,
  output logic skpOverrun
);

  localparam int unsigned TW = (SKP_INTERVAL > 1) ? $clog2(SKP_INTERVAL) : 1;
  localparam logic [TW-1:0] LAST = TW'(SKP_INTERVAL - 1);

  logic [TW-1:0] cnt;
  logic          expire;

  assign expire = linkUp && (cnt == LAST);

  // Interval counter and owed-SKP flag; an expiry on the same edge as a take keeps it set
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      skpPending <= 1'b0;
      skpOverrun <= 1'b0;
    end else if (!linkUp) begin
      cnt        <= '0;
      skpPending <= 1'b0;
      skpOverrun <= 1'b0;
    end else begin
      cnt        <= expire ? '0 : cnt + TW'(1);
      skpOverrun <= expire && skpPending && !skpTaken;
      if (expire) begin
        skpPending <= 1'b1;
      end else if (skpTaken) begin
        skpPending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/os_tx_scheduler.sv
// TX ordered-set scheduler: arbitrates LTSSM TS1/TS2 bursts, periodic SKP and EIOS
// entry onto a single valid/ready command bus to the ordered-set generator.
//   clk, reset (async, active-low), gen : current generation, linkUp : SKP timer enable
//   tsReq/tsType/tsCount : burst request, eiosReq : EIOS request
//   bus (master) : osValid/osType out, genReady in
//   tsAck, tsAbort, eiosDone, skpOverrun : one-cycle pulses
//   skpPending : SKP owed, busy : scheduler not idle
module os_tx_scheduler
  import os_sched_pkg::*;
#(
  parameter int unsigned SKP_INTERVAL = 1180,
  parameter int unsigned CNT_W        = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           gen,
  input  logic                 linkUp,
  input  logic                 tsReq,
  input  logic                 tsType,
  input  logic [CNT_W-1:0]     tsCount,
  input  logic                 eiosReq,
  os_tx_scheduler_if.master    bus,
  output logic                 tsAck,
  output logic                 tsAbort,
  output logic                 eiosDone,
  output logic                 skpPending,
  output logic                 skpOverrun,
  output logic                 busy
);

  state_e           state, state_n;
  logic             os_valid, valid_n;
  os_type_e         os_type, type_n;
  logic [CNT_W-1:0] remaining, rem_n;
  logic             ts_type, ts_type_n;
  logic             eios_pending, eios_pend_n;
  logic [1:0]       eios_left, eios_left_n;
  logic             ack_n, abort_n, done_n, busy_n;
  logic             xfer, skp_taken;

  assign bus.osValid = os_valid;
  assign bus.osType  = os_type;
  assign xfer        = os_valid && bus.genReady;
  assign skp_taken   = xfer && (state == ST_SKP);

  os_skp_timer #(.SKP_INTERVAL(SKP_INTERVAL)) u_skp_timer (
    .clk        (clk),
    .reset      (reset),
    .linkUp     (linkUp),
    .skpTaken   (skp_taken),
    .skpPending (skpPending),
    .skpOverrun (skpOverrun)
  );

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      os_valid     <= 1'b0;
      os_type      <= OS_NONE;
      remaining    <= '0;
      ts_type      <= 1'b0;
      eios_pending <= 1'b0;
      eios_left    <= '0;
      tsAck        <= 1'b0;
      tsAbort      <= 1'b0;
      eiosDone     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      os_valid     <= valid_n;
      os_type      <= type_n;
      remaining    <= rem_n;
      ts_type      <= ts_type_n;
      eios_pending <= eios_pend_n;
      eios_left    <= eios_left_n;
      tsAck        <= ack_n;
      tsAbort      <= abort_n;
      eiosDone     <= done_n;
      busy         <= busy_n;
    end
  end

  // Request capture, burst/EIOS bookkeeping and next-command selection
  always_comb begin
    state_n     = state;
    valid_n     = os_valid;
    type_n      = os_type;
    rem_n       = remaining;
    ts_type_n   = ts_type;
    eios_pend_n = eios_pending;
    eios_left_n = eios_left;
    ack_n       = 1'b0;
    abort_n     = 1'b0;
    done_n      = 1'b0;

    if (eiosReq && (state != ST_EIOS)) begin
      eios_pend_n = 1'b1;
    end

    // A new burst is only taken when none is active and no EIOS is owed or arriving
    if (tsReq && (remaining == '0) && !eios_pending && !eiosReq) begin
      ts_type_n = tsType;
      rem_n     = tsCount;
      ack_n     = (tsCount == '0);
    end

    if (xfer && (state == ST_TS)) begin
      rem_n = remaining - CNT_W'(1);
      ack_n = (remaining == CNT_W'(1));
    end

    if (xfer && (state == ST_EIOS)) begin
      if (eios_left == 2'd1) begin
        done_n      = 1'b1;
        eios_pend_n = 1'b0;
        state_n     = ST_IDLE;
        valid_n     = 1'b0;
        type_n      = OS_NONE;
      end else begin
        eios_left_n = eios_left - 2'd1;
      end
    end else if ((state == ST_IDLE) || xfer) begin
      // Decision point: EIOS > SKP > remaining TS > idle
      if (eios_pend_n) begin
        state_n     = ST_EIOS;
        valid_n     = 1'b1;
        type_n      = OS_EIOS;
        eios_left_n = eios_count(gen);
        if (rem_n != '0) begin
          rem_n   = '0;
          abort_n = 1'b1;
        end
      end else if (skpPending && !skp_taken) begin
        state_n = ST_SKP;
        valid_n = 1'b1;
        type_n  = OS_SKP;
      end else if (rem_n != '0) begin
        state_n = ST_TS;
        valid_n = 1'b1;
        type_n  = ts_type_n ? OS_TS2 : OS_TS1;
      end else begin
        state_n = ST_IDLE;
        valid_n = 1'b0;
        type_n  = OS_NONE;
      end
    end

    busy_n = (state_n != ST_IDLE);
  end

endmodule

// File: doc/os_tx_scheduler.md
# os_tx_scheduler

Arbitrates the transmit ordered-set path of the PCIe PHY between three requesters: LTSSM TS1/TS2 bursts, periodic SKP insertion and Electrical-Idle (EIOS) entry. Issues one ordered-set command at a time to the ordered-set generator over a valid/ready handshake and tracks burst counts. Sits between the LTSSM and the TX ordered-set generator; it is the TX-side companion of the RX ordered-set decoder.

## Interface
- SKP_INTERVAL, 1180, clock cycles between SKP schedule points while linkUp
- CNT_W, 11, width of TS burst count
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- gen  in  3  current generation (3'b001..3'b101)
- linkUp  in  1  link up; enables SKP timer
- tsReq  in  1  TS burst request, single-cycle pulse
- tsType  in  1  0 = TS1, 1 = TS2; sampled with tsReq
- tsCount  in  CNT_W  number of TS to send; sampled with tsReq
- eiosReq  in  1  EIOS request, single-cycle pulse
- genReady  in  1  generator accepts a command this cycle
- osValid  out  1  command valid
- osType  out  3  0 NONE, 1 TS1, 2 TS2, 3 SKP, 4 EIOS
- tsAck  out  1  one-cycle pulse: burst fully sent
- tsAbort  out  1  one-cycle pulse: burst cut short by EIOS
- eiosDone  out  1  one-cycle pulse: last EIOS transferred
- skpPending  out  1  SKP owed, not yet transferred
- skpOverrun  out  1  one-cycle pulse: timer expired while skpPending already set
- busy  out  1  state != IDLE

## Operation
- Transfer = osValid && genReady at a rising clk edge. Once osValid is high, osType is held stable until transfer.
- States: IDLE, TS, SKP, EIOS.
- Priority at each decision point (IDLE, or the edge of a transfer): EIOS pending > skpPending > remaining TS > IDLE.
- Decision points never fall mid-command; SKP and EIOS are only inserted between ordered sets.
- tsReq is accepted only when no burst is active (remaining == 0) and no EIOS is pending; otherwise it is ignored. Acceptance latches tsType and remaining = tsCount.
- tsCount == 0: no TS is sent; tsAck pulses on the cycle after tsReq.
- Each TS transfer decrements remaining. The transfer that takes remaining to 0 produces a tsAck pulse on the following cycle. SKP transfers do not decrement remaining.
- SKP timer:
  - Counts every cycle while linkUp; at SKP_INTERVAL-1 it sets skpPending and wraps to 0.
  - Expiry while skpPending is already set: skpPending stays 1 (no accumulation) and skpOverrun pulses.
  - linkUp low: timer and skpPending are held at 0.
  - A SKP transfer clears skpPending. If an expiry lands on the same edge, skpPending stays set.
- EIOS:
  - eiosReq sets eiosPending, including mid-burst.
  - EIOS count is 1 for gen 1-2 and 2 for gen >= 3, latched when the EIOS state is entered.
  - Entering EIOS with remaining != 0: remaining is cleared and tsAbort pulses; tsAck is not asserted.
  - After the last EIOS transfer: eiosDone pulses, eiosPending clears, state goes to IDLE.
  - eiosReq arriving while in EIOS is ignored.
- Simultaneous tsReq and eiosReq in IDLE: EIOS wins and tsReq is ignored.

## Timing
- Reset values: all outputs 0, osType = NONE, state IDLE, counters 0, all pending flags 0.
- Reset asserted mid-operation drops osValid immediately (asynchronously); nothing resumes after reset release.
- Outputs are registered.
- tsReq sampled at edge N: osValid = 1, osType = TS1/TS2 after edge N.
- Back-to-back: the next command is presented on the same edge as the transfer, so a continuous genReady yields one ordered set per cycle.
- genReady low holds the current command with no loss.
- skpPending rises the cycle after the timer reaches SKP_INTERVAL-1. SKP is issued at the next decision point.
- The tsAck, tsAbort, eiosDone and skpOverrun pulses are exactly one cycle wide.

## Structure
- Shared package os_sched_pkg:
  - osType encodings (OS_NONE, OS_TS1, OS_TS2, OS_SKP, OS_EIOS)
  - state encoding
  - EIOS counts per generation
  - the symbol constants already used by the RX decoder (COM, gen3TS1, gen3TS2, gen3SKIP)
- One sub-module, os_skp_timer, containing the counter, skpPending and skpOverrun, with clk, reset, linkUp and skpTaken inputs. The top-level module holds the FSM and burst counter.

## Test plan
- tsReq with tsType 0 and tsCount 4, genReady held 1 -> osType TS1 on 4 consecutive cycles; tsAck on the cycle after the 4th transfer; busy returns to 0.
- Same burst with genReady toggling 1,0,1,0 -> exactly 4 transfers; osType stable during stalls; no duplicate or lost TS.
- SKP_INTERVAL = 8, linkUp = 1, tsCount 20, tsType 1 -> a SKP is inserted between TS2s every 8 cycles; TS2 transfers total 20; tsAck fires once.
- eiosReq after the 3rd of 10 TS1s with gen 3 -> tsAbort pulse, 2 EIOS transfers, eiosDone pulse, no tsAck, state IDLE.
- genReady = 0 for 20 cycles with SKP_INTERVAL = 8 -> skpPending stays 1 and skpOverrun pulses at each subsequent expiry; a single SKP is sent when genReady rises.
- Reset asserted while osValid = 1 mid-burst -> osValid and busy are 0 immediately; after release, no command is issued until a new request.
